lfsr_prbs_test_ctrl: RTL and testbench
======================================

# lfsr_prbs_test_ctrl

Sequencer for one PRBS bit-error-rate test run. It drives the reset and enable of an external PRBS generator and checker pair, and runs a fixed number of words. It accumulates the per-word bit-error counts reported by the checker and signals completion. It sits above the generator/checker datapath and is driven by software or a test-control block through a start/abort/done interface.

## Interface
- OUTPUT_WIDTH, 8: data word width of the generator and checker; sets the width of err_bits.
- COUNT_WIDTH, 32: width of the word-count and words-run counters.
- ERR_WIDTH, 32: width of the error accumulator.
- PRIME_CYCLES, 4: number of enabled cycles after seeding during which checker errors are ignored (checker lock time); must be ≥1.
- DRAIN_CYCLES, 2: number of cycles after the last RUN word during which in-flight checker results are still accumulated; must be ≥1.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to begin a run; honoured only in IDLE.
- abort  in  1  terminate the current run early; ignored in IDLE and DONE.
- word_count  in  COUNT_WIDTH  number of RUN words; sampled on the cycle start is accepted.
- gen_rst, chk_rst  out  1  synchronous reset strobes to generator and checker.
- gen_enable, chk_enable  out  1  advance generator and checker by one word.
- err_valid  in  1  err_bits is valid this cycle.
- err_bits  in  $clog2(OUTPUT_WIDTH+1)  number of errored bits in the reported word.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on DONE entry.
- aborted  out  1  last run ended by abort; held until the next start.
- err_total  out  ERR_WIDTH  saturating accumulated bit errors of the last or current run.
- words_run  out  COUNT_WIDTH  number of RUN words issued in the last or current run.

## Operation
- States: IDLE, SEED, PRIME, RUN, DRAIN, DONE.
- IDLE:
  - When start=1: latch word_count; clear err_total, words_run and aborted; go to SEED.
  - abort is ignored in IDLE. If start and abort are both high in IDLE, start is accepted.
- SEED, 1 cycle: gen_rst=chk_rst=1, enables 0. Go to PRIME.
- PRIME, PRIME_CYCLES cycles: gen_enable=chk_enable=1. err_valid is ignored. Then:
  - latched word_count≠0 → RUN.
  - latched word_count=0 → DRAIN.
- RUN: gen_enable=chk_enable=1 every cycle. words_run increments each cycle. Leave for DRAIN after the cycle in which words_run reaches the latched count, so exactly word_count enabled cycles occur.
- DRAIN, DRAIN_CYCLES cycles: enables 0. Errors are still accumulated. Then go to DONE.
- DONE, 1 cycle: done=1, busy=1. Then go to IDLE.
- Accumulation:
  - In RUN and DRAIN, when err_valid=1: err_total += err_bits.
  - err_total saturates at all-ones and never wraps.
  - err_valid is ignored in IDLE, SEED, PRIME and DONE.
- Abort:
  - abort=1 in SEED, PRIME, RUN or DRAIN: go to DONE next cycle and set aborted=1.
  - Enables drop immediately on that next cycle. words_run and err_total freeze at their values including the abort cycle.
- start while busy is ignored; it is not queued.
- word_count changes after acceptance have no effect.

## Timing
- Reset (rst_n low, asynchronous): state IDLE. busy, done, aborted, gen_rst, chk_rst, gen_enable and chk_enable are all 0. err_total=0, words_run=0.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Start acceptance:
  - start at edge N → SEED during cycle N+1 (gen_rst=1, busy=1).
  - First PRIME enable at N+2.
  - First RUN enable at N+2+PRIME_CYCLES.
- Total busy time = 1 + PRIME_CYCLES + word_count + DRAIN_CYCLES + 1 cycles.
- done pulses on the last busy cycle. busy falls on the cycle after done.
- A start on the cycle busy falls is accepted.
- words_run wraps never: latched word_count bounds it.
- rst_n asserted mid-run: immediate return to IDLE and all outputs cleared. No done pulse.

## Test plan
- Reset values: assert rst_n=0 mid-RUN → same-cycle busy=0, enables=0, err_total=0, no done.
- Nominal run: PRIME_CYCLES=4, DRAIN_CYCLES=2, word_count=10, err_valid=1 with err_bits=1 on 3 RUN cycles → exactly 10 RUN enables plus 4 PRIME enables, err_total=3, words_run=10, done pulse on cycle 18 after start, aborted=0.
- Prime masking and drain capture:
  - err_bits=5 during PRIME → not counted.
  - err_bits=2 in the 2nd DRAIN cycle → err_total=2.
- Zero-length run: word_count=0 → PRIME goes straight to DRAIN, words_run=0, busy for 8 cycles.
- Abort: abort on the 3rd RUN cycle → next cycle DONE, aborted=1, words_run=3, enables low. A following start clears aborted.
- Saturation and ignored start: ERR_WIDTH=4, err_bits=8 on 3 words → err_total=15. start pulses while busy → no restart and run length unchanged.

Source files
------------

// File: rtl/lfsr_prbs_test_ctrl.sv
// Sequencer for one PRBS bit-error-rate run: seeds and advances an external
// generator/checker pair, counts issued words and accumulates reported bit errors.
module lfsr_prbs_test_ctrl #(
   parameter int unsigned OUTPUT_WIDTH = 8,
   parameter int unsigned COUNT_WIDTH  = 32,
   parameter int unsigned ERR_WIDTH    = 32,
   parameter int unsigned PRIME_CYCLES = 4,
   parameter int unsigned DRAIN_CYCLES = 2
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  start,
   input  logic                                  abort,
   input  logic [COUNT_WIDTH-1:0]                word_count,
   output logic                                  gen_rst,
   output logic                                  chk_rst,
   output logic                                  gen_enable,
   output logic                                  chk_enable,
   input  logic                                  err_valid,
   input  logic [$clog2(OUTPUT_WIDTH+1)-1:0]     err_bits,
   output logic                                  busy,
   output logic                                  done,
   output logic                                  aborted,
   output logic [ERR_WIDTH-1:0]                  err_total,
   output logic [COUNT_WIDTH-1:0]                words_run
);

   localparam int unsigned ERRB_W  = $clog2(OUTPUT_WIDTH + 1);
   localparam int unsigned CYC_MAX = (PRIME_CYCLES > DRAIN_CYCLES) ? PRIME_CYCLES : DRAIN_CYCLES;
   localparam int unsigned CYC_W   = $clog2(CYC_MAX + 1);
   localparam int unsigned SUM_W   = ((ERR_WIDTH > ERRB_W) ? ERR_WIDTH : ERRB_W) + 1;
   localparam logic [ERR_WIDTH-1:0] ERR_MAX = '1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEED,
      ST_PRIME,
      ST_RUN,
      ST_DRAIN,
      ST_DONE
   } state_e;

   state_e                 state_q, state_d;
   logic [CYC_W-1:0]       cyc_q, cyc_d;
   logic [COUNT_WIDTH-1:0] count_q, count_d;
   logic [COUNT_WIDTH-1:0] words_q, words_d;
   logic [ERR_WIDTH-1:0]   err_q, err_d;
   logic                   aborted_q, aborted_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic                   seed_q, seed_d;
   logic                   en_q, en_d;
   logic [SUM_W-1:0]       err_sum;
   logic [ERR_WIDTH-1:0]   err_sat;
   logic                   in_run_phase;

   // Next-state, counters, saturating accumulation and output decode of the next state
   always_comb begin
      state_d   = state_q;
      cyc_d     = cyc_q;
      count_d   = count_q;
      words_d   = words_q;
      err_d     = err_q;
      aborted_d = aborted_q;

      err_sum = SUM_W'(err_q) + SUM_W'(err_bits);
      err_sat = (err_sum > SUM_W'(ERR_MAX)) ? ERR_MAX : err_sum[ERR_WIDTH-1:0];

      in_run_phase = (state_q == ST_SEED) || (state_q == ST_PRIME) ||
                     (state_q == ST_RUN)  || (state_q == ST_DRAIN);

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d   = ST_SEED;
               count_d   = word_count;
               words_d   = '0;
               err_d     = '0;
               aborted_d = 1'b0;
            end
         end
         ST_SEED: begin
            state_d = ST_PRIME;
            cyc_d   = CYC_W'(PRIME_CYCLES - 1);
         end
         ST_PRIME: begin
            if (cyc_q == '0) begin
               if (count_q != '0) begin
                  state_d = ST_RUN;
               end else begin
                  state_d = ST_DRAIN;
                  cyc_d   = CYC_W'(DRAIN_CYCLES - 1);
               end
            end else begin
               cyc_d = cyc_q - CYC_W'(1);
            end
         end
         ST_RUN: begin
            words_d = words_q + COUNT_WIDTH'(1);
            if (words_d == count_q) begin
               state_d = ST_DRAIN;
               cyc_d   = CYC_W'(DRAIN_CYCLES - 1);
            end
         end
         ST_DRAIN: begin
            if (cyc_q == '0) begin
               state_d = ST_DONE;
            end else begin
               cyc_d = cyc_q - CYC_W'(1);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Checker results only count while words are flowing or draining
      if (((state_q == ST_RUN) || (state_q == ST_DRAIN)) && err_valid) begin
         err_d = err_sat;
      end

      // Abort overrides the normal transition but keeps this cycle's counts
      if (abort && in_run_phase) begin
         state_d   = ST_DONE;
         aborted_d = 1'b1;
      end

      busy_d = (state_d != ST_IDLE);
      done_d = (state_d == ST_DONE);
      seed_d = (state_d == ST_SEED);
      en_d   = (state_d == ST_PRIME) || (state_d == ST_RUN);
   end

   // State, counters and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cyc_q     <= '0;
         count_q   <= '0;
         words_q   <= '0;
         err_q     <= '0;
         aborted_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         seed_q    <= 1'b0;
         en_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         cyc_q     <= cyc_d;
         count_q   <= count_d;
         words_q   <= words_d;
         err_q     <= err_d;
         aborted_q <= aborted_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         seed_q    <= seed_d;
         en_q      <= en_d;
      end
   end

   assign gen_rst    = seed_q;
   assign chk_rst    = seed_q;
   assign gen_enable = en_q;
   assign chk_enable = en_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign aborted    = aborted_q;
   assign err_total  = err_q;
   assign words_run  = words_q;

endmodule

// File: tb/tb_lfsr_prbs_test_ctrl.sv
// Self-checking bench: directed vector table plus randomized run against a phase-arithmetic model.
module tb_lfsr_prbs_test_ctrl;

   localparam int unsigned PRIME = 4;
   localparam int unsigned DRAIN = 2;

   localparam int PH_IDLE  = 0;
   localparam int PH_SEED  = 1;
   localparam int PH_PRIME = 2;
   localparam int PH_RUN   = 3;
   localparam int PH_DRAIN = 4;
   localparam int PH_DONE  = 5;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        abort;
   logic        err_valid;
   logic [31:0] word_count;
   logic [3:0]  err_bits;

   logic        gen_rst, chk_rst, gen_enable, chk_enable, busy, done, aborted;
   logic [31:0] err_total, words_run;
   logic        gen_rst4, chk_rst4, gen_enable4, chk_enable4, busy4, done4, aborted4;
   logic [3:0]  err_total4;
   logic [31:0] words_run4;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   lfsr_prbs_test_ctrl #(
      .OUTPUT_WIDTH(8), .COUNT_WIDTH(32), .ERR_WIDTH(32),
      .PRIME_CYCLES(PRIME), .DRAIN_CYCLES(DRAIN)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .word_count(word_count),
      .gen_rst(gen_rst), .chk_rst(chk_rst), .gen_enable(gen_enable), .chk_enable(chk_enable),
      .err_valid(err_valid), .err_bits(err_bits), .busy(busy), .done(done), .aborted(aborted),
      .err_total(err_total), .words_run(words_run)
   );

   lfsr_prbs_test_ctrl #(
      .OUTPUT_WIDTH(8), .COUNT_WIDTH(32), .ERR_WIDTH(4),
      .PRIME_CYCLES(PRIME), .DRAIN_CYCLES(DRAIN)
   ) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .word_count(word_count),
      .gen_rst(gen_rst4), .chk_rst(chk_rst4), .gen_enable(gen_enable4), .chk_enable(chk_enable4),
      .err_valid(err_valid), .err_bits(err_bits), .busy(busy4), .done(done4), .aborted(aborted4),
      .err_total(err_total4), .words_run(words_run4)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      int wc;
      int err_pos;
      int err_n;
      int bits;
      int abort_pos;
      int s1;
      int s2;
      int e_busy;
      int e_en;
      int e_words;
      int e_err;
      int e_err4;
      int e_ab;
   } vec_t;

   vec_t vecs[11];

   task automatic run_vec(input int idx, input vec_t v);
      int pos, busy_n, en_n, rst_cnt, done_n, done_pos, en_mis;
      bit  ev;
      pos = 1; busy_n = 0; en_n = 0; rst_cnt = 0; done_n = 0; done_pos = 0; en_mis = 0;
      start = 1'b1;
      word_count = 32'(v.wc);
      @(posedge clk); #1;
      start = 1'b0;
      word_count = 32'($urandom_range(0, 40));
      while (busy === 1'b1 && pos < 300) begin
         busy_n++;
         if (gen_enable === 1'b1) en_n++;
         if (gen_enable !== chk_enable || gen_rst !== chk_rst) en_mis++;
         if (gen_rst === 1'b1) rst_cnt++;
         if (done === 1'b1) begin
            done_n++;
            done_pos = pos;
         end
         if (pos == 1) chk($sformatf("v%0d aborted_clear", idx), 64'(aborted), 64'(0));
         ev = (v.err_n > 0) && (pos >= v.err_pos) && (pos < v.err_pos + 2 * v.err_n) &&
              (((pos - v.err_pos) % 2) == 0);
         err_valid = ev;
         err_bits  = 4'(v.bits);
         abort     = (pos == v.abort_pos);
         start     = (pos == v.s1) || (pos == v.s2);
         @(posedge clk); #1;
         pos++;
      end
      err_valid = 1'b0; abort = 1'b0; start = 1'b0; err_bits = '0;
      if (pos >= 300) chk($sformatf("v%0d busy_timeout", idx), 64'(pos), 64'(0));
      chk($sformatf("v%0d busy_cycles", idx), 64'(busy_n), 64'(v.e_busy));
      chk($sformatf("v%0d enables", idx), 64'(en_n), 64'(v.e_en));
      chk($sformatf("v%0d gen_chk_match", idx), 64'(en_mis), 64'(0));
      chk($sformatf("v%0d seed_cycles", idx), 64'(rst_cnt), 64'(1));
      chk($sformatf("v%0d done_count", idx), 64'(done_n), 64'(1));
      chk($sformatf("v%0d done_pos", idx), 64'(done_pos), 64'(v.e_busy));
      chk($sformatf("v%0d words_run", idx), 64'(words_run), 64'(v.e_words));
      chk($sformatf("v%0d err_total", idx), 64'(err_total), 64'(v.e_err));
      chk($sformatf("v%0d err_total_w4", idx), 64'(err_total4), 64'(v.e_err4));
      chk($sformatf("v%0d aborted", idx), 64'(aborted), 64'(v.e_ab));
   endtask

   // ---------------- behavioural model for random run ----------------
   int      m_pos, m_wc;
   bit      m_done, m_ab;
   longint  m_err, m_err4, m_words;

   function automatic int phase_of(input int pos, input int wc, input bit dn);
      if (pos == 0) return PH_IDLE;
      if (dn) return PH_DONE;
      if (pos == 1) return PH_SEED;
      if (pos <= 1 + int'(PRIME)) return PH_PRIME;
      if (pos <= 1 + int'(PRIME) + wc) return PH_RUN;
      if (pos <= 1 + int'(PRIME) + wc + int'(DRAIN)) return PH_DRAIN;
      return PH_DONE;
   endfunction

   task automatic model_step();
      int ph;
      ph = phase_of(m_pos, m_wc, m_done);
      if (ph == PH_IDLE) begin
         if (start) begin
            m_pos = 1; m_wc = int'(word_count); m_err = 0; m_err4 = 0; m_words = 0; m_ab = 0;
         end
      end else if (ph == PH_DONE) begin
         m_pos = 0; m_done = 0;
      end else begin
         if ((ph == PH_RUN || ph == PH_DRAIN) && err_valid) begin
            m_err  = m_err + longint'(err_bits);
            if (m_err > 64'hFFFF_FFFF) m_err = 64'hFFFF_FFFF;
            m_err4 = m_err4 + longint'(err_bits);
            if (m_err4 > 15) m_err4 = 15;
         end
         if (ph == PH_RUN) m_words++;
         if (abort) begin
            m_done = 1; m_ab = 1;
         end else begin
            m_pos++;
            if (phase_of(m_pos, m_wc, 1'b0) == PH_DONE) m_done = 1;
         end
      end
   endtask

   task automatic compare_model(input int cyc);
      int ph;
      ph = phase_of(m_pos, m_wc, m_done);
      chk($sformatf("r%0d busy", cyc), 64'(busy), 64'(ph != PH_IDLE));
      chk($sformatf("r%0d done", cyc), 64'(done), 64'(ph == PH_DONE));
      chk($sformatf("r%0d gen_rst", cyc), 64'({gen_rst, chk_rst}), 64'(ph == PH_SEED ? 3 : 0));
      chk($sformatf("r%0d enable", cyc), 64'({gen_enable, chk_enable}),
          64'((ph == PH_PRIME || ph == PH_RUN) ? 3 : 0));
      chk($sformatf("r%0d aborted", cyc), 64'(aborted), 64'(m_ab));
      chk($sformatf("r%0d err_total", cyc), 64'(err_total), 64'(m_err));
      chk($sformatf("r%0d words_run", cyc), 64'(words_run), 64'(m_words));
      chk($sformatf("r%0d w4_err_total", cyc), 64'(err_total4), 64'(m_err4));
      chk($sformatf("r%0d w4_ctrl", cyc),
          64'({busy4, done4, aborted4, gen_rst4, chk_rst4, gen_enable4, chk_enable4}),
          64'({busy, done, aborted, gen_rst, chk_rst, gen_enable, chk_enable}));
      chk($sformatf("r%0d w4_words", cyc), 64'(words_run4), 64'(m_words));
   endtask

   initial begin
      //            wc err_pos n bits abort s1 s2 busy en words err err4 ab
      vecs[0]  = '{10, 7, 3, 1, 0, 0,  0, 18, 14, 10,  3,  3, 0};
      vecs[1]  = '{ 4, 2, 2, 5, 0, 0,  0, 12,  8,  4,  0,  0, 0};
      vecs[2]  = '{ 4,11, 1, 2, 0, 0,  0, 12,  8,  4,  2,  2, 0};
      vecs[3]  = '{ 4,12, 1, 7, 0, 0,  0, 12,  8,  4,  0,  0, 0};
      vecs[4]  = '{ 0, 6, 1, 3, 0, 0,  0,  8,  4,  0,  3,  3, 0};
      vecs[5]  = '{10, 8, 1, 4, 8, 0,  0,  9,  7,  3,  4,  4, 1};
      vecs[6]  = '{ 5, 6, 3, 8, 0, 3, 13, 13,  9,  5, 24, 15, 0};
      vecs[7]  = '{ 5, 0, 0, 0, 1, 0,  0,  2,  0,  0,  0,  0, 1};
      vecs[8]  = '{ 2, 9, 1, 1, 8, 0,  0,  9,  6,  2,  0,  0, 1};
      vecs[9]  = '{ 6, 3, 1, 5, 3, 0,  0,  4,  2,  0,  0,  0, 1};
      vecs[10] = '{ 1, 6, 2, 8, 0, 0,  0,  9,  5,  1, 16, 15, 0};

      rst_n = 1'b0; start = 1'b0; abort = 1'b0; err_valid = 1'b0;
      err_bits = '0; word_count = '0;
      #3;
      chk("reset_busy", 64'(busy), 64'(0));
      chk("reset_ctrl", 64'({done, aborted, gen_rst, chk_rst, gen_enable, chk_enable}), 64'(0));
      chk("reset_err_total", 64'(err_total), 64'(0));
      chk("reset_words_run", 64'(words_run), 64'(0));
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

      // Reset in the middle of RUN clears everything at once, with no done pulse
      start = 1'b1; word_count = 32'd10;
      @(posedge clk); #1;
      start = 1'b0;
      for (int p = 1; p < 8; p++) begin
         err_valid = (p == 6 || p == 7);
         err_bits  = 4'd2;
         @(posedge clk); #1;
      end
      err_valid = 1'b0;
      chk("midrun_err_before_reset", 64'(err_total), 64'(4));
      chk("midrun_words_before_reset", 64'(words_run), 64'(2));
      chk("midrun_enable_before_reset", 64'(gen_enable), 64'(1));
      rst_n = 1'b0;
      #1;
      chk("midrun_reset_busy", 64'(busy), 64'(0));
      chk("midrun_reset_enables", 64'({gen_enable, chk_enable}), 64'(0));
      chk("midrun_reset_err_total", 64'(err_total), 64'(0));
      chk("midrun_reset_words_run", 64'(words_run), 64'(0));
      chk("midrun_reset_done", 64'(done), 64'(0));
      for (int k = 0; k < 2; k++) begin
         @(posedge clk); #1;
         chk("midrun_reset_hold_done", 64'({done, busy}), 64'(0));
      end
      rst_n = 1'b1;

      // Randomized traffic against the model, started from a clean reset
      m_pos = 0; m_wc = 0; m_done = 0; m_ab = 0; m_err = 0; m_err4 = 0; m_words = 0;
      for (int c = 0; c < 1500; c++) begin
         start      = ($urandom_range(0, 3) == 0);
         abort      = ($urandom_range(0, 29) == 0);
         err_valid  = $urandom_range(0, 1) == 1;
         err_bits   = 4'($urandom_range(0, 8));
         word_count = 32'($urandom_range(0, 12));
         model_step();
         @(posedge clk); #1;
         compare_model(c);
      end
      start = 1'b0; abort = 1'b0; err_valid = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
